// File: rtl/matrix_transpose_seq_pkg.sv
// matrix_pkg: shared constants, encodings and layout helper for the
// sequential matrix operators (transpose/copy, add, multiply) and benches.
//   MAX_DIM / DATA_W / DIM_W : default geometry
//   MAT_W                    : width of a flat MAX_DIM x MAX_DIM matrix bus
//   state_e                  : sequential operator FSM states
//   mode_e                   : transpose/copy selection
//   elem_idx(r,c)            : bit offset of element (r,c), row-major
package matrix_pkg;

    localparam int MAX_DIM = 5;
    localparam int DATA_W  = 8;
    localparam int DIM_W   = 3;
    localparam int MAT_W   = MAX_DIM * MAX_DIM * DATA_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic {
        MODE_TRANSPOSE = 1'b0,
        MODE_COPY      = 1'b1
    } mode_e;

    function automatic int unsigned elem_idx(input int unsigned r, input int unsigned c);
        return (r * MAX_DIM + c) * DATA_W;
    endfunction

endpackage

// File: rtl/matrix_transpose_seq_elem_counter.sv
// matrix_elem_counter: row-major (row, col) scan counter for sequential
// matrix operators. Column wraps at runtime n; both wrap to 0 after the
// final element so the counters never exceed MAX_DIM-1.
//   clk, rst_n    : clock, asynchronous active-low reset
//   clr_i         : synchronous clear to (0,0), has priority over en_i
//   en_i          : advance one element
//   m_i, n_i      : active rows / columns (1..MAX_DIM)
//   row_o, col_o  : current element
//   last_o        : current element is (m-1, n-1)
module matrix_elem_counter
    import matrix_pkg::*;
#(
    parameter int MAX_DIM = matrix_pkg::MAX_DIM,
    parameter int DIM_W   = matrix_pkg::DIM_W,
    localparam int CNT_W  = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [DIM_W-1:0] m_i,
    input  logic [DIM_W-1:0] n_i,
    output logic [CNT_W-1:0] row_o,
    output logic [CNT_W-1:0] col_o,
    output logic             last_o
);

    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic [DIM_W-1:0] row_last, col_last;
    logic             col_wrap;

    assign row_last = m_i - DIM_W'(1);
    assign col_last = n_i - DIM_W'(1);
    assign col_wrap = (DIM_W'(col_q) == col_last);
    assign last_o   = col_wrap && (DIM_W'(row_q) == row_last);

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr_i || (en_i && last_o)) begin
            row_d = '0;
            col_d = '0;
        end else if (en_i) begin
            if (col_wrap) begin
                col_d = '0;
                row_d = row_q + CNT_W'(1);
            end else begin
                col_d = col_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o = row_q;
    assign col_o = col_q;

endmodule

// File: rtl/matrix_transpose_seq.sv
// matrix_transpose_seq: sequential transpose/copy engine, one element per clock.
//   clk, reset           : clock, asynchronous active-low reset
//   start                : request, sampled only while idle
//   mode_in              : 0 = transpose, 1 = copy
//   m_in, n_in           : source rows / columns
//   matrix_in            : flat row-major source, element (r,c) at (r*MAX_DIM+c)*DATA_W
//   busy                 : element moves in progress
//   done                 : one-cycle completion pulse (success or error)
//   valid, error         : result status, held until the next accepted start
//   m_out, n_out         : result dimensions
//   matrix_out           : result, same layout as matrix_in
// All outputs come straight from registers.
module matrix_transpose_seq
    import matrix_pkg::*;
#(
    parameter int MAX_DIM = matrix_pkg::MAX_DIM,
    parameter int DATA_W  = matrix_pkg::DATA_W,
    parameter int DIM_W   = matrix_pkg::DIM_W
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              mode_in,
    input  logic [DIM_W-1:0]                  m_in,
    input  logic [DIM_W-1:0]                  n_in,
    input  logic [MAX_DIM*MAX_DIM*DATA_W-1:0] matrix_in,
    output logic                              busy,
    output logic                              done,
    output logic                              valid,
    output logic                              error,
    output logic [DIM_W-1:0]                  m_out,
    output logic [DIM_W-1:0]                  n_out,
    output logic [MAX_DIM*MAX_DIM*DATA_W-1:0] matrix_out
);

    localparam int MAT_BITS = MAX_DIM * MAX_DIM * DATA_W;
    localparam int CNT_W    = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
    localparam logic [DIM_W-1:0] DIM_MAX = DIM_W'(MAX_DIM);

    // Offset uses this instance's geometry so overridden parameters stay consistent.
    function automatic int unsigned elem_off(input logic [CNT_W-1:0] r, input logic [CNT_W-1:0] c);
        return (32'(r) * MAX_DIM + 32'(c)) * DATA_W;
    endfunction

    state_e                state_q, state_d;
    mode_e                 mode_q, mode_d;
    logic [DIM_W-1:0]      m_q, m_d, n_q, n_d;
    logic [MAT_BITS-1:0]   src_q, src_d, res_q, res_d;
    logic                  busy_q, busy_d, done_q, done_d;
    logic                  valid_q, valid_d, error_q, error_d;
    logic [DIM_W-1:0]      m_out_q, m_out_d, n_out_q, n_out_d;

    logic                  cnt_clr, cnt_en, cnt_last;
    logic [CNT_W-1:0]      row, col;
    logic                  dims_bad;

    assign dims_bad = (m_in == '0) || (n_in == '0) || (m_in > DIM_MAX) || (n_in > DIM_MAX);

    matrix_elem_counter #(
        .MAX_DIM (MAX_DIM),
        .DIM_W   (DIM_W)
    ) u_cnt (
        .clk    (clk),
        .rst_n  (reset),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .m_i    (m_q),
        .n_i    (n_q),
        .row_o  (row),
        .col_o  (col),
        .last_o (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        m_d     = m_q;
        n_d     = n_q;
        src_d   = src_q;
        res_d   = res_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        error_d = error_q;
        m_out_d = m_out_q;
        n_out_d = n_out_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d   = matrix_in;
                    m_d     = m_in;
                    n_d     = n_in;
                    mode_d  = mode_e'(mode_in);
                    res_d   = '0;
                    valid_d = 1'b0;
                    error_d = 1'b0;
                    m_out_d = '0;
                    n_out_d = '0;
                    cnt_clr = 1'b1;
                    if (dims_bad) begin
                        error_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        busy_d  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                cnt_en = 1'b1;
                if (mode_q == MODE_COPY)
                    res_d[elem_off(row, col) +: DATA_W] = src_q[elem_off(row, col) +: DATA_W];
                else
                    res_d[elem_off(col, row) +: DATA_W] = src_q[elem_off(row, col) +: DATA_W];
                if (cnt_last) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    valid_d = 1'b1;
                    m_out_d = (mode_q == MODE_COPY) ? m_q : n_q;
                    n_out_d = (mode_q == MODE_COPY) ? n_q : m_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_TRANSPOSE;
            m_q     <= '0;
            n_q     <= '0;
            src_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
            m_out_q <= '0;
            n_out_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            m_q     <= m_d;
            n_q     <= n_d;
            src_q   <= src_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            error_q <= error_d;
            m_out_q <= m_out_d;
            n_out_q <= n_out_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign valid      = valid_q;
    assign error      = error_q;
    assign m_out      = m_out_q;
    assign n_out      = n_out_q;
    assign matrix_out = res_q;

endmodule

// File: tb/tb_matrix_transpose_seq.sv
module tb_matrix_transpose_seq;
    import matrix_pkg::*;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             mode_in = 1'b0;
    logic [DIM_W-1:0] m_in = '0;
    logic [DIM_W-1:0] n_in = '0;
    logic [MAT_W-1:0] matrix_in = '0;
    logic             busy, done, valid, error;
    logic [DIM_W-1:0] m_out, n_out;
    logic [MAT_W-1:0] matrix_out;

    int total = 0;
    int bad   = 0;

    matrix_transpose_seq #(
        .MAX_DIM (MAX_DIM),
        .DATA_W  (DATA_W),
        .DIM_W   (DIM_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode_in    (mode_in),
        .m_in       (m_in),
        .n_in       (n_in),
        .matrix_in  (matrix_in),
        .busy       (busy),
        .done       (done),
        .valid      (valid),
        .error      (error),
        .m_out      (m_out),
        .n_out      (n_out),
        .matrix_out (matrix_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [MAT_W-1:0] act, input logic [MAT_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int el(input logic [MAT_W-1:0] mat, input int r, input int c);
        return int'(mat[elem_idx(r, c) +: DATA_W]);
    endfunction

    // Row-major counting matrix base, base+1, ...; cells outside m x n get junk.
    function automatic logic [MAT_W-1:0] seq_mat(input int m, input int n, input int base);
        logic [MAT_W-1:0] v = '0;
        for (int r = 0; r < MAX_DIM; r++)
            for (int c = 0; c < MAX_DIM; c++)
                v[elem_idx(r, c) +: DATA_W] = (r < m && c < n) ? DATA_W'(base + r * n + c) : 8'hEE;
        return v;
    endfunction

    // Transaction-level reference: a run takes m*n edges, then the whole result appears.
    logic             m_busy = 0, m_done = 0, m_valid = 0, m_err = 0;
    int               m_mo = 0, m_no = 0, m_pmo = 0, m_pno = 0, m_left = 0;
    logic [MAT_W-1:0] m_res = '0, m_pend = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_done = 0; m_valid = 0; m_err = 0;
            m_mo = 0; m_no = 0; m_left = 0; m_res = '0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0; m_done = 1; m_valid = 1;
                    m_res = m_pend; m_mo = m_pmo; m_no = m_pno;
                end
            end else if (start) begin
                int m, n;
                m = int'(m_in);
                n = int'(n_in);
                m_valid = 0; m_err = 0; m_mo = 0; m_no = 0; m_res = '0;
                if (m == 0 || n == 0 || m > MAX_DIM || n > MAX_DIM) begin
                    m_err = 1; m_done = 1;
                end else begin
                    m_pend = '0;
                    for (int r = 0; r < m; r++)
                        for (int c = 0; c < n; c++)
                            if (mode_in) m_pend[elem_idx(r, c) +: DATA_W] = matrix_in[elem_idx(r, c) +: DATA_W];
                            else         m_pend[elem_idx(c, r) +: DATA_W] = matrix_in[elem_idx(r, c) +: DATA_W];
                    m_pmo  = mode_in ? m : n;
                    m_pno  = mode_in ? n : m;
                    m_left = m * n;
                    m_busy = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_busy", 32'(busy), 32'(m_busy));
        chk("cyc_done", 32'(done), 32'(m_done));
        chk("cyc_valid", 32'(valid), 32'(m_valid));
        chk("cyc_error", 32'(error), 32'(m_err));
        chk("cyc_m_out", 32'(m_out), 32'(m_mo));
        chk("cyc_n_out", 32'(n_out), 32'(m_no));
        if (!m_busy) chkw("cyc_matrix_out", matrix_out, m_res);
    end

    task automatic go(input logic md, input int m, input int n, input logic [MAT_W-1:0] mat);
        @(posedge clk); #1;
        start = 1'b1; mode_in = md; m_in = DIM_W'(m); n_in = DIM_W'(n); matrix_in = mat;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Edges after the start edge until done; also counts samples with busy high.
    task automatic wait_done(output int edges, output int busy_cnt);
        edges = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && edges < 200) begin
            @(posedge clk); #1;
            edges++;
            if (busy) busy_cnt++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    int edges, bcnt;

    initial begin
        #3;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(valid), 0);
        chkw("rst_matrix", matrix_out, '0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;

        // 1x3 transpose
        go(1'b0, 1, 3, seq_mat(1, 3, 1));
        wait_done(edges, bcnt);
        chk("t13_latency", edges, 3);
        chk("t13_valid", 32'(valid), 1);
        chk("t13_m_out", 32'(m_out), 3);
        chk("t13_n_out", 32'(n_out), 1);
        chk("t13_e00", el(matrix_out, 0, 0), 1);
        chk("t13_e10", el(matrix_out, 1, 0), 2);
        chk("t13_e20", el(matrix_out, 2, 0), 3);
        chk("t13_e01", el(matrix_out, 0, 1), 0);

        // 5x5 transpose
        go(1'b0, 5, 5, seq_mat(5, 5, 1));
        wait_done(edges, bcnt);
        chk("t55_latency", edges, 25);
        chk("t55_busy_cycles", bcnt, 25);
        chk("t55_e04", el(matrix_out, 0, 4), 21);
        chk("t55_e40", el(matrix_out, 4, 0), 5);
        @(posedge clk); #1;
        chk("t55_done_width", 32'(done), 0);
        chk("t55_valid_held", 32'(valid), 1);

        // invalid dimensions
        go(1'b0, 0, 3, seq_mat(1, 3, 1));
        chk("bad03_error", 32'(error), 1);
        chk("bad03_done", 32'(done), 1);
        chk("bad03_busy", 32'(busy), 0);
        chk("bad03_valid", 32'(valid), 0);
        chk("bad03_m_out", 32'(m_out), 0);
        chkw("bad03_matrix", matrix_out, '0);
        go(1'b0, 6, 2, seq_mat(2, 2, 1));
        chk("bad62_error", 32'(error), 1);
        chk("bad62_done", 32'(done), 1);
        chk("bad62_n_out", 32'(n_out), 0);
        go(1'b0, 2, 2, seq_mat(2, 2, 10));
        chk("clr_error", 32'(error), 0);
        chk("clr_busy", 32'(busy), 1);
        wait_done(edges, bcnt);
        chk("t22_latency", edges, 4);
        chk("t22_e01", el(matrix_out, 0, 1), 12);

        // copy 2x3
        go(1'b1, 2, 3, seq_mat(2, 3, 1));
        wait_done(edges, bcnt);
        chk("cp23_latency", edges, 6);
        chk("cp23_m_out", 32'(m_out), 2);
        chk("cp23_n_out", 32'(n_out), 3);
        chk("cp23_e12", el(matrix_out, 1, 2), 6);
        chk("cp23_e13", el(matrix_out, 1, 3), 0);

        // 3x3 with a restart attempt while busy
        go(1'b0, 3, 3, seq_mat(3, 3, 1));
        @(posedge clk); #1;
        start = 1'b1; m_in = DIM_W'(1); n_in = DIM_W'(1);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(edges, bcnt);
        chk("t33_latency", edges + 2, 9);
        chk("t33_m_out", 32'(m_out), 3);
        chk("t33_e01", el(matrix_out, 0, 1), 4);

        // async reset mid-run
        go(1'b0, 3, 3, seq_mat(3, 3, 20));
        repeat (4) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_valid", 32'(valid), 0);
        chkw("arst_matrix", matrix_out, '0);
        @(posedge clk); #3 reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("arst_no_done", 32'(done), 0);
        end
        go(1'b0, 2, 2, seq_mat(2, 2, 30));
        wait_done(edges, bcnt);
        chk("post_rst_latency", edges, 4);
        chk("post_rst_e10", el(matrix_out, 1, 0), 31);

        // back-to-back, start held through the done cycle
        @(posedge clk); #1;
        start = 1'b1; mode_in = 1'b0; m_in = DIM_W'(2); n_in = DIM_W'(2); matrix_in = seq_mat(2, 2, 40);
        @(posedge clk); #1;
        mode_in = 1'b1; m_in = DIM_W'(1); n_in = DIM_W'(2); matrix_in = seq_mat(1, 2, 50);
        repeat (4) @(posedge clk);
        #1;
        chk("b2b_a_done", 32'(done), 1);
        chk("b2b_a_m_out", 32'(m_out), 2);
        chk("b2b_a_e01", el(matrix_out, 0, 1), 42);
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_valid_drop", 32'(valid), 0);
        chk("b2b_b_busy", 32'(busy), 1);
        wait_done(edges, bcnt);
        chk("b2b_b_latency", edges, 2);
        chk("b2b_b_valid", 32'(valid), 1);
        chk("b2b_b_m_out", 32'(m_out), 1);
        chk("b2b_b_n_out", 32'(n_out), 2);
        chk("b2b_b_e01", el(matrix_out, 0, 1), 51);

        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/matrix_transpose_seq.md
Name: matrix_transpose_seq

Overview:
Sequential, parametrised matrix transpose/copy engine for the matrix calculator datapath. It accepts a flat row-major matrix of up to MAX_DIM x MAX_DIM elements on a start handshake. It validates the dimensions, moves one element per clock into a result register, then reports done/valid/error. It supersedes the single-shot combinational transpose, and copy mode lets other operators reuse it as a staging buffer.

Parameters:
MAX_DIM, 5, maximum rows/columns supported.
DATA_W, 8, element width in bits (unsigned, not interpreted).
DIM_W, 3, width of dimension ports; must hold MAX_DIM.

Ports:
clk  input  1  system clock, all state on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset).
start  input  1  request; sampled only in IDLE.
mode_in  input  1  0 = transpose, 1 = copy.
m_in  input  DIM_W  source row count.
n_in  input  DIM_W  source column count.
matrix_in  input  MAX_DIM*MAX_DIM*DATA_W  source; element (r,c) at bit offset (r*MAX_DIM+c)*DATA_W.
busy  output  1  high while copying elements.
done  output  1  one-cycle completion pulse (success or error).
valid  output  1  result valid; held until next accepted start.
error  output  1  dimension error; held until next accepted start.
m_out  output  DIM_W  result rows.
n_out  output  DIM_W  result columns.
matrix_out  output  MAX_DIM*MAX_DIM*DATA_W  result, same layout as matrix_in.

Behaviour:
- Reset (reset=0, async): state IDLE; busy, done, valid, error = 0; m_out, n_out = 0; source and result registers all zero; counters zero. Reset mid-run aborts with no done pulse.
- Every output is registered. There are no combinational paths from inputs to outputs.
- FSM states: IDLE, RUN.
- IDLE:
  - On start=1 at edge E0: latch matrix_in, m_in, n_in and mode_in into internal registers. Clear the result register, valid, error, m_out and n_out. Reset the row and column counters to 0.
  - Dimension check: if m_in==0, n_in==0, m_in>MAX_DIM or n_in>MAX_DIM, stay in IDLE. At the same edge E0 set error=1 and done=1. valid stays 0 and busy never rises.
  - Otherwise go to RUN and set busy=1.
- RUN:
  - Each edge copies one element from latched source (r,c).
  - Transpose mode writes it to result (c,r). Copy mode writes it to result (r,c).
  - Scan is row-major: c increments; at c==n-1, c wraps to 0 and r increments.
  - The edge that writes (m-1,n-1) also does the following: busy=0; done=1; valid=1; m_out and n_out set to n,m (transpose) or m,n (copy); FSM to IDLE.
- Latency: done and valid rise exactly m*n edges after E0. done is cleared on the following edge unless a new error or completion occurs.
- start while busy is ignored; inputs may change freely during RUN because the latched copies are used.
- start in the cycle done is high (FSM is IDLE) is accepted; valid and error clear at that edge.
- Result elements outside the m_out x n_out region are always zero.
- During RUN, matrix_out shows the partially filled result. Consumers use it only when valid=1.
- Counters are width ceil(log2(MAX_DIM)) and never exceed MAX_DIM-1.

Decomposition:
- Package matrix_pkg holds:
  - MAX_DIM, DATA_W, DIM_W defaults and derived MAT_W = MAX_DIM*MAX_DIM*DATA_W.
  - The FSM state encoding (IDLE=0, RUN=1).
  - The mode encoding (MODE_TRANSPOSE=0, MODE_COPY=1).
  - The element offset function elem_idx(r,c) = (r*MAX_DIM+c)*DATA_W, shared with the add/multiply units and benches.
- One sub-module, matrix_elem_counter: row/column scan counter with clear, enable, wrap at runtime n, and last flag at (m-1,n-1). It is reused by other sequential matrix operators.

Test Plan:
- 1x3 transpose of [1,2,3]:
  - Required: done=1, valid=1 exactly 3 edges after start.
  - Required: m_out=3, n_out=1; result column entries (0,0)=1, (1,0)=2, (2,0)=3; all other elements 0.
- 5x5 transpose with in(r,c)=r*5+c+1:
  - Required: busy high for 25 cycles; done pulse is 1 cycle wide.
  - Required: out(i,j)=in(j,i) for all i,j, e.g. out(0,4)=21, out(4,0)=5.
- Invalid dims, 0x3 then 6x2 (MAX_DIM=5):
  - Required: error=1 and done=1 at the start edge; busy stays 0, valid=0, m_out=n_out=0, matrix_out all zero.
  - Required: a following valid start clears error.
- Copy mode 2x3 of [[1,2,3],[4,5,6]]:
  - Required: after 6 edges m_out=2, n_out=3; matrix_out equals matrix_in within the region, zero elsewhere.
- 3x3 transpose with disturbances:
  - Re-assert start with different m_in/n_in at cycle 2: ignored; the original result appears after 9 edges.
  - Second run: assert reset=0 asynchronously after 4 cycles. Required: busy, done, valid and matrix_out drop to 0 immediately and no done pulse follows.
  - After release, a new 2x2 run completes normally in 4 edges.
- Back-to-back runs with start held during the done cycle:
  - Required: second run accepted; valid drops for its duration and re-rises with the second result.
